// File: rtl/front_icon_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : front_icon_dispatch_queue
// Description : Front-end buffer between rename and the backend interconnect
//               controller. Accepts up to NUM_ENQ icon instructions per cycle
//               in program order into a circular FIFO and hands them out
//               through one registered slot per dispatch channel.
//
// Ports
//   clk                          clock
//   reset                        synchronous, active-high reset
//   flush_i                      pipeline flush, discards everything held
//   enq_instr_i [NUM_ENQ]        instructions from rename, lane 0 oldest
//   enq_valid_i [NUM_ENQ]        per-lane valid, may be sparse
//   enq_ready_o                  all-or-nothing accept for the whole batch
//   icon_instr_dispatch_o        per-channel slot contents
//   icon_instr_dispatch_valid_o  per-channel slot full
//   icon_instr_dispatch_ready_i  per-channel accept from the controller
//   occupancy_o                  FIFO entry count (channel slots excluded)
//   stall_cycles_o               (ICON_DISPATCH_STATS_EN) enqueue stall cycles
//   dispatched_count_o           (ICON_DISPATCH_STATS_EN) handshakes seen
//
// Build option : define ICON_DISPATCH_STATS_EN to add the two saturating
//                32-bit statistics counters and their ports.
// The icon instruction type is carried as an INSTR_W-bit vector.
//
// Revision    : 1.0 - initial release
// ============================================================================
module front_icon_dispatch_queue #(
    parameter int LOG2_NUM_ICON_CHANNELS = 2,
    parameter int NUM_ENQ                = 2,
    parameter int DEPTH                  = 8,
    parameter int INSTR_W                = 32
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   flush_i,
    input  logic [NUM_ENQ-1:0][INSTR_W-1:0]                        enq_instr_i,
    input  logic [NUM_ENQ-1:0]                                     enq_valid_i,
    output logic                                                   enq_ready_o,
    output logic [(2**LOG2_NUM_ICON_CHANNELS)-1:0][INSTR_W-1:0]    icon_instr_dispatch_o,
    output logic [(2**LOG2_NUM_ICON_CHANNELS)-1:0]                 icon_instr_dispatch_valid_o,
    input  logic [(2**LOG2_NUM_ICON_CHANNELS)-1:0]                 icon_instr_dispatch_ready_i,
    output logic [$clog2(DEPTH):0]                                 occupancy_o
`ifdef ICON_DISPATCH_STATS_EN
    ,
    output logic [31:0]                                            stall_cycles_o,
    output logic [31:0]                                            dispatched_count_o
`endif
);

    localparam int NUM_ICON_CHANNELS = 2**LOG2_NUM_ICON_CHANNELS;
    localparam int IDX_W             = $clog2(DEPTH);
    localparam int PTR_W             = IDX_W + 1;
    localparam int CH_CNT_W          = LOG2_NUM_ICON_CHANNELS + 1;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Pointers carry an extra wrap bit so that full and empty are distinct.
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];

    slot_state_e        slot_state_q [NUM_ICON_CHANNELS];
    slot_state_e        slot_state_d [NUM_ICON_CHANNELS];
    logic [INSTR_W-1:0] slot_data_q  [NUM_ICON_CHANNELS];
    logic [INSTR_W-1:0] slot_data_d  [NUM_ICON_CHANNELS];

    logic [PTR_W-1:0]   w_count;
    logic [PTR_W-1:0]   w_load_cnt;
    logic [PTR_W-1:0]   w_enq_cnt;

    // Count is the pointer distance; modular subtraction handles the wrap bit.
    assign w_count     = tail_q - head_q;
    assign occupancy_o = w_count;

    // Depends on registered state only, so rename sees a stable ready.
    assign enq_ready_o = (PTR_W'(DEPTH) - w_count) >= PTR_W'(NUM_ENQ);

    // ------------------------------------------------------------------
    // Next-state: refill of free slots, batch enqueue, flush override.
    // ------------------------------------------------------------------
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        mem_d        = mem_q;
        slot_state_d = slot_state_q;
        slot_data_d  = slot_data_q;
        w_load_cnt   = '0;
        w_enq_cnt    = '0;

        // Refill works from the registered count, so entries written this
        // cycle can never be loaded before the next edge.
        for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
            if ((slot_state_q[c] == SLOT_EMPTY) || icon_instr_dispatch_ready_i[c]) begin
                if (w_load_cnt < w_count) begin
                    slot_data_d[c]  = mem_q[IDX_W'(head_q + w_load_cnt)];
                    slot_state_d[c] = SLOT_FULL;
                    w_load_cnt      = w_load_cnt + PTR_W'(1);
                end else begin
                    slot_state_d[c] = SLOT_EMPTY;
                end
            end
        end
        head_d = head_q + w_load_cnt;

        // Valid lanes are compacted in lane order starting at tail.
        if (enq_ready_o) begin
            for (int l = 0; l < NUM_ENQ; l++) begin
                if (enq_valid_i[l]) begin
                    mem_d[IDX_W'(tail_q + w_enq_cnt)] = enq_instr_i[l];
                    w_enq_cnt                          = w_enq_cnt + PTR_W'(1);
                end
            end
        end
        tail_d = tail_q + w_enq_cnt;

        // Flush drops held and incoming work; a slot handshake on this edge
        // has already happened on the wire and is not undone.
        if (flush_i) begin
            head_d      = '0;
            tail_d      = '0;
            mem_d       = mem_q;
            slot_data_d = slot_data_q;
            for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
                slot_state_d[c] = SLOT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
                slot_state_q[c] <= SLOT_EMPTY;
                slot_data_q[c]  <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            mem_q        <= mem_d;
            slot_state_q <= slot_state_d;
            slot_data_q  <= slot_data_d;
        end
    end

    generate
        for (genvar c = 0; c < NUM_ICON_CHANNELS; c++) begin : g_out
            assign icon_instr_dispatch_valid_o[c] = (slot_state_q[c] == SLOT_FULL);
            assign icon_instr_dispatch_o[c]       = slot_data_q[c];
        end
    endgenerate

`ifdef ICON_DISPATCH_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics; cleared by reset only, flush leaves them.
    // ------------------------------------------------------------------
    logic [31:0]         stall_cycles_q, stall_cycles_d;
    logic [31:0]         dispatched_count_q, dispatched_count_d;
    logic [CH_CNT_W-1:0] w_hs_cnt;
    logic [32:0]         w_disp_sum;

    always_comb begin
        w_hs_cnt = '0;
        for (int c = 0; c < NUM_ICON_CHANNELS; c++) begin
            w_hs_cnt = w_hs_cnt
                     + CH_CNT_W'(icon_instr_dispatch_valid_o[c] & icon_instr_dispatch_ready_i[c]);
        end
        w_disp_sum         = {1'b0, dispatched_count_q} + 33'(w_hs_cnt);
        dispatched_count_d = w_disp_sum[32] ? '1 : w_disp_sum[31:0];

        stall_cycles_d = stall_cycles_q;
        if ((|enq_valid_i) && !enq_ready_o && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q     <= '0;
            dispatched_count_q <= '0;
        end else begin
            stall_cycles_q     <= stall_cycles_d;
            dispatched_count_q <= dispatched_count_d;
        end
    end

    assign stall_cycles_o     = stall_cycles_q;
    assign dispatched_count_o = dispatched_count_q;
`else
    // Statistics disabled: no counter state is built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_front_icon_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_front_icon_dispatch_queue
// Description : Directed bench for front_icon_dispatch_queue with a queue
//               based reference model compared every cycle, plus literal
//               expectations for the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_front_icon_dispatch_queue;

    localparam int NCH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush_i;
    logic [1:0][31:0]      enq_instr;
    logic [1:0]            enq_valid;
    logic                  enq_ready;
    logic [NCH-1:0][31:0]  disp;
    logic [NCH-1:0]        dv;
    logic [NCH-1:0]        dr;
    logic [3:0]            occ;
`ifdef ICON_DISPATCH_STATS_EN
    logic [31:0]           stall_cnt;
    logic [31:0]           disp_cnt;
`endif

    front_icon_dispatch_queue #(
        .LOG2_NUM_ICON_CHANNELS (2),
        .NUM_ENQ                (2),
        .DEPTH                  (8),
        .INSTR_W                (32)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .flush_i                     (flush_i),
        .enq_instr_i                 (enq_instr),
        .enq_valid_i                 (enq_valid),
        .enq_ready_o                 (enq_ready),
        .icon_instr_dispatch_o       (disp),
        .icon_instr_dispatch_valid_o (dv),
        .icon_instr_dispatch_ready_i (dr),
        .occupancy_o                 (occ)
`ifdef ICON_DISPATCH_STATS_EN
        ,
        .stall_cycles_o              (stall_cnt),
        .dispatched_count_o          (disp_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int dut_hs_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: FIFO as a queue, slots as valid/data pairs.
    // ------------------------------------------------------------------
    logic [31:0] m_fifo[$];
    logic [31:0] m_data [NCH];
    bit          m_v    [NCH];
    int unsigned m_stall = 0;
    int unsigned m_disp  = 0;

    function automatic bit m_ready();
        return (8 - m_fifo.size()) >= 2;
    endfunction

    function automatic logic [NCH-1:0] m_valid_vec();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_v[c];
        return v;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        rdy = m_ready();
        if (reset) begin
            m_fifo.delete();
            for (int c = 0; c < NCH; c++) begin
                m_v[c]    = 1'b0;
                m_data[c] = '0;
            end
            m_stall = 0;
            m_disp  = 0;
        end else begin
            for (int c = 0; c < NCH; c++) if (m_v[c] && dr[c]) m_disp++;
            if ((|enq_valid) && !rdy) m_stall++;
            if (flush_i) begin
                m_fifo.delete();
                for (int c = 0; c < NCH; c++) m_v[c] = 1'b0;
            end else begin
                // Pre-edge FIFO feeds free slots oldest-first; new lanes join after.
                for (int c = 0; c < NCH; c++) begin
                    if (!m_v[c] || dr[c]) begin
                        if (m_fifo.size() > 0) begin
                            m_data[c] = m_fifo.pop_front();
                            m_v[c]    = 1'b1;
                        end else begin
                            m_v[c] = 1'b0;
                        end
                    end
                end
                if (rdy) begin
                    for (int l = 0; l < 2; l++) if (enq_valid[l]) m_fifo.push_back(enq_instr[l]);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 64'(dv), 64'(m_valid_vec()));
            check("occupancy", 64'(occ), 64'(m_fifo.size()));
            check("enq_ready", 64'(enq_ready), 64'(m_ready()));
            for (int c = 0; c < NCH; c++) begin
                if (m_v[c]) check("slot_data", 64'(disp[c]), 64'(m_data[c]));
            end
`ifdef ICON_DISPATCH_STATS_EN
            check("stall_cycles", 64'(stall_cnt), 64'(m_stall));
            check("dispatched_count", 64'(disp_cnt), 64'(m_disp));
`endif
            if (!reset) begin
                for (int c = 0; c < NCH; c++) if (dv[c] && dr[c]) dut_hs_total++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [31:0] tag = 32'h1000;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_batch(input logic [1:0] v);
        enq_instr[0] = tag;
        enq_instr[1] = tag + 32'd1;
        tag          = tag + 32'd2;
        enq_valid    = v;
    endtask

    task automatic drain(input string nm);
        int n;
        enq_valid = 2'b00;
        dr        = 4'b1111;
        n         = 0;
        while (((dv != 4'b0000) || (occ != 4'd0)) && (n < 20)) begin
            cyc();
            n++;
        end
        check(nm, {60'd0, dv} | 64'(occ), 64'd0);
        dr = 4'b0000;
    endtask

    initial begin
        int start_hs;
        int sent;
        int guard;
`ifdef ICON_DISPATCH_STATS_EN
        logic [31:0] disp_before;
`endif
        reset     = 1'b1;
        flush_i   = 1'b0;
        enq_instr = '0;
        enq_valid = 2'b00;
        dr        = 4'b0000;
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 64'(dv), 64'd0);
        check("rst_occ", 64'(occ), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        for (int c = 0; c < NCH; c++) check("rst_disp", 64'(disp[c]), 64'd0);

        // Basic latency: A,B enqueued, visible in slots two edges later
        enq_instr[0] = 32'hA; enq_instr[1] = 32'hB; enq_valid = 2'b11;
        cyc();
        enq_valid = 2'b00;
        check("lat_occ_c1", 64'(occ), 64'd2);
        check("lat_valid_c1", 64'(dv), 64'd0);
        cyc();
        check("lat_valid_c2", 64'(dv), 64'b0011);
        check("lat_ch0", 64'(disp[0]), 64'hA);
        check("lat_ch1", 64'(disp[1]), 64'hB);
        check("lat_occ_c2", 64'(occ), 64'd0);

        // Sparse lanes: only lane 1 valid, lands in ch0
        dr = 4'b0011;
        cyc();
        dr = 4'b0000;
        check("sparse_drained", 64'(dv), 64'd0);
        enq_instr[0] = 32'hDEAD; enq_instr[1] = 32'hC; enq_valid = 2'b10;
        cyc();
        enq_valid = 2'b00;
        check("sparse_occ", 64'(occ), 64'd1);
        cyc();
        check("sparse_valid", 64'(dv), 64'b0001);
        check("sparse_ch0", 64'(disp[0]), 64'hC);
        enq_instr[0] = 32'hD; enq_instr[1] = 32'hEEEE; enq_valid = 2'b01;
        cyc();
        enq_valid = 2'b00;
        cyc();
        check("sparse_valid2", 64'(dv), 64'b0011);
        check("sparse_ch1", 64'(disp[1]), 64'hD);
        drain("sparse_drain");

        // Full and back-pressure: six batches with no ready
        for (int b = 0; b < 6; b++) begin
            enq_instr[0] = 32'h200 + 32'(2*b);
            enq_instr[1] = 32'h201 + 32'(2*b);
            enq_valid    = 2'b11;
            cyc();
        end
        enq_instr[0] = 32'h20C; enq_instr[1] = 32'h20D; enq_valid = 2'b11;
        check("full_occ", 64'(occ), 64'd8);
        check("full_enq_ready", 64'(enq_ready), 64'd0);
        check("full_valid", 64'(dv), 64'b1111);
        dr = 4'b0001;
        cyc();
        dr = 4'b0000;
        check("full_reload_ch0", 64'(disp[0]), 64'h204);
        check("full_occ_after", 64'(occ), 64'd7);
        enq_valid = 2'b01;
        check("full_ready_at7", 64'(enq_ready), 64'd0);
        cyc();
        check("full_occ_hold", 64'(occ), 64'd7);
        drain("full_drain");

        // Back-to-back stream with all channels ready
        dr = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            set_batch(2'b11);
            check("stream_enq_ready", 64'(enq_ready), 64'd1);
            cyc();
        end
        drain("stream_drain");

        // Wrap: 20 instrs with alternating ready patterns
        start_hs = dut_hs_total;
        sent     = 0;
        guard    = 0;
        while ((sent < 20) && (guard < 200)) begin
            dr = guard[0] ? 4'b0101 : 4'b1010;
            if (enq_ready) begin
                set_batch(2'b11);
                sent += 2;
            end else begin
                enq_valid = 2'b00;
            end
            cyc();
            guard++;
        end
        check("wrap_sent", 64'(sent), 64'd20);
        drain("wrap_drain");
        cyc();
        check("wrap_dispatched", 64'(dut_hs_total - start_hs), 64'd20);

        // Flush collision with a ch2 handshake and an enqueue
        set_batch(2'b11);
        cyc();
        set_batch(2'b11);
        cyc();
        enq_valid = 2'b00;
        cyc();
        check("flush_pre_valid", 64'(dv), 64'b1111);
`ifdef ICON_DISPATCH_STATS_EN
        disp_before = disp_cnt;
`endif
        flush_i = 1'b1;
        dr      = 4'b0100;
        set_batch(2'b11);
        cyc();
        flush_i   = 1'b0;
        dr        = 4'b0000;
        enq_valid = 2'b00;
        check("flush_valid", 64'(dv), 64'd0);
        check("flush_occ", 64'(occ), 64'd0);
`ifdef ICON_DISPATCH_STATS_EN
        check("flush_disp_cnt", 64'(disp_cnt - disp_before), 64'd1);
`endif
        cyc();
        check("flush_dropped", 64'(dv), 64'd0);

        // Reset mid-operation
        set_batch(2'b11);
        cyc();
        enq_valid = 2'b00;
        cyc();
        check("midrst_pre", 64'(dv), 64'b0011);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst_valid", 64'(dv), 64'd0);
        check("midrst_occ", 64'(occ), 64'd0);
        cyc();
        cyc();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
